riscv_core_icache_controller: RTL and testbench

Control stage directly upstream of the I-cache data array: holds tags and valid bits, detects fetch hits and misses, and runs AXI line refills. It drives the array's read enable, write enable, block-replace and offset strobes. A fetch whose 4 bytes straddle two lines (RV32C halfword at line byte 30) can trigger a two-line refill. It stalls the core until every byte of the fetch is resident.

---
 rtl/riscv_core_icache_controller.sv | 158 +++++++++++++++
 tb/tb_riscv_core_icache_controller.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/riscv_core_icache_controller.sv
// rtl/riscv_core_icache_controller.sv - I-cache tag/valid store, hit detection and AXI line refill control.
// Optional ICACHE_PERF_CNT_EN adds hit and miss-detection counters.
module riscv_core_icache_controller #(
    parameter int ADDR_WIDTH         = 32,
    parameter int INDEX_WIDTH        = 7,
    parameter int BLOCK_OFFSET_WIDTH = 3,
    parameter int AXI_DATA_WIDTH     = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_flush,
    output logic                  o_stall,
    output logic                  o_rd_en,
    output logic                  o_wr_en,
    output logic                  o_block_replace,
    output logic                  o_offset,
    output logic                  o_fetch_err,
    output logic                  o_axi_arvalid,
    output logic [ADDR_WIDTH-1:0] o_axi_araddr,
    input  logic                  i_axi_arready,
    input  logic                  i_axi_rvalid,
    output logic                  o_axi_rready,
`ifdef ICACHE_PERF_CNT_EN
    output logic [31:0]           o_hit_cnt,
    output logic [31:0]           o_miss_cnt,
`endif
    input  logic [1:0]            i_axi_rresp
);

    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - BLOCK_OFFSET_WIDTH - 2;
    localparam int LINE_OFF  = $clog2(AXI_DATA_WIDTH / 8);
    localparam int LINES     = 1 << INDEX_WIDTH;

    typedef enum logic [2:0] {IDLE, AR_A, R_A, AR_B, R_B} state_t;

    state_t                  state;
    logic [LINES-1:0]        valid;
    logic [TAG_WIDTH-1:0]    tags [LINES];
    logic [ADDR_WIDTH-1:0]   araddr_q;
    logic                    b_miss_q;
    logic                    flush_pending;

    logic [ADDR_WIDTH-1:0]   addr_b;
    logic [INDEX_WIDTH-1:0]  idx_a, idx_b, wr_idx;
    logic [TAG_WIDTH-1:0]    tag_a, tag_b, wr_tag;
    logic [ADDR_WIDTH-1:0]   line_a, line_b;
    logic                    need_b, hit_a, hit_b, idle, miss_start;
    logic                    in_r, resp_ok, line_wr, to_b, go_idle;
    logic                    unused_addr_lo;

    // Line B is the line holding the upper halfword of a fetch at byte offset 30.
    assign addr_b = i_addr + ADDR_WIDTH'(2);
    assign unused_addr_lo = ^addr_b[LINE_OFF-1:0];

    assign idx_a  = i_addr[LINE_OFF +: INDEX_WIDTH];
    assign tag_a  = i_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign idx_b  = addr_b[LINE_OFF +: INDEX_WIDTH];
    assign tag_b  = addr_b[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign line_a = {i_addr[ADDR_WIDTH-1:LINE_OFF], {LINE_OFF{1'b0}}};
    assign line_b = {addr_b[ADDR_WIDTH-1:LINE_OFF], {LINE_OFF{1'b0}}};

    assign need_b = &i_addr[LINE_OFF-1:1];
    assign hit_a  = valid[idx_a] && (tags[idx_a] == tag_a);
    assign hit_b  = !need_b || (valid[idx_b] && (tags[idx_b] == tag_b));

    assign idle       = (state == IDLE);
    assign miss_start = idle && i_req && !i_flush && !(hit_a && hit_b);

    assign in_r    = (state == R_A) || (state == R_B);
    assign resp_ok = (i_axi_rresp == 2'b00);
    assign line_wr = in_r && i_axi_rvalid && resp_ok && !i_rst;
    assign to_b    = (state == R_A) && i_axi_rvalid && resp_ok && b_miss_q;
    assign go_idle = in_r && i_axi_rvalid && !to_b;

    assign wr_idx = (state == R_B) ? idx_b : idx_a;
    assign wr_tag = (state == R_B) ? tag_b : tag_a;

    assign o_rd_en         = i_req && hit_a && hit_b && idle;
    assign o_stall         = i_req && !(idle && hit_a && hit_b);
    assign o_wr_en         = line_wr;
    assign o_block_replace = line_wr;
    assign o_offset        = line_wr && (state == R_B);
    assign o_fetch_err     = in_r && i_axi_rvalid && !resp_ok && !i_rst;
    assign o_axi_arvalid   = ((state == AR_A) || (state == AR_B)) && !i_rst;
    assign o_axi_rready    = in_r && !i_rst;
    assign o_axi_araddr    = o_axi_arvalid ? araddr_q : '0;

    always_ff @(posedge i_clk) begin
        if (line_wr) begin
            tags[wr_idx] <= wr_tag;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            valid         <= '0;
            araddr_q      <= '0;
            b_miss_q      <= 1'b0;
            flush_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_flush) begin
                        valid <= '0;
                    end else if (miss_start && !hit_a) begin
                        state    <= AR_A;
                        araddr_q <= line_a;
                        b_miss_q <= !hit_b;
                    end else if (miss_start) begin
                        state    <= AR_B;
                        araddr_q <= line_b;
                        b_miss_q <= 1'b0;
                    end
                end
                AR_A: if (i_axi_arready) state <= R_A;
                AR_B: if (i_axi_arready) state <= R_B;
                R_A, R_B: begin
                    if (line_wr) begin
                        valid[wr_idx] <= 1'b1;
                    end
                    if (to_b) begin
                        state    <= AR_B;
                        araddr_q <= line_b;
                    end else if (go_idle) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A flush seen mid-refill also kills the line just written.
            if (go_idle) begin
                flush_pending <= 1'b0;
                if (flush_pending || i_flush) begin
                    valid <= '0;
                end
            end else if (i_flush && !idle) begin
                flush_pending <= 1'b1;
            end
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_hit_cnt  <= '0;
            o_miss_cnt <= '0;
        end else begin
            if (o_rd_en)    o_hit_cnt  <= o_hit_cnt + 32'd1;
            if (miss_start) o_miss_cnt <= o_miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_riscv_core_icache_controller.sv
// tb/tb_riscv_core_icache_controller.sv - directed self-checking bench for riscv_core_icache_controller.
module tb_riscv_core_icache_controller;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_flush;
    logic        o_stall, o_rd_en, o_wr_en, o_block_replace, o_offset, o_fetch_err;
    logic        o_axi_arvalid;
    logic [31:0] o_axi_araddr;
    logic        i_axi_arready, i_axi_rvalid, o_axi_rready;
    logic [1:0]  i_axi_rresp;

    int n_assert = 0;
    int n_fail   = 0;

    riscv_core_icache_controller dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_req           (i_req),
        .i_addr          (i_addr),
        .i_flush         (i_flush),
        .o_stall         (o_stall),
        .o_rd_en         (o_rd_en),
        .o_wr_en         (o_wr_en),
        .o_block_replace (o_block_replace),
        .o_offset        (o_offset),
        .o_fetch_err     (o_fetch_err),
        .o_axi_arvalid   (o_axi_arvalid),
        .o_axi_araddr    (o_axi_araddr),
        .i_axi_arready   (i_axi_arready),
        .i_axi_rvalid    (i_axi_rvalid),
        .o_axi_rready    (o_axi_rready),
        .i_axi_rresp     (i_axi_rresp)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst = 1'b1; i_req = 1'b0; i_addr = 32'h0; i_flush = 1'b0;
        i_axi_arready = 1'b1; i_axi_rvalid = 1'b1; i_axi_rresp = 2'b00;
        tick; tick;
        #1;
        chk("rst_arvalid", {31'b0, o_axi_arvalid}, 32'd0);
        chk("rst_rready",  {31'b0, o_axi_rready}, 32'd0);
        chk("rst_wr_en",   {31'b0, o_wr_en}, 32'd0);
        chk("rst_araddr",  o_axi_araddr, 32'h0);

        // Idle with no request: all strobes quiet.
        tick; i_rst = 1'b0; #1;
        chk("idle_stall", {31'b0, o_stall}, 32'd0);
        chk("idle_rd_en", {31'b0, o_rd_en}, 32'd0);

        // Cold single-line miss at 0x100.
        tick; i_req = 1'b1; i_addr = 32'h100; #1;
        chk("c1_n_stall", {31'b0, o_stall}, 32'd1);
        chk("c1_n_rd_en", {31'b0, o_rd_en}, 32'd0);
        tick; #1;
        chk("c1_ar_valid", {31'b0, o_axi_arvalid}, 32'd1);
        chk("c1_ar_addr", o_axi_araddr, 32'h100);
        tick; #1;
        chk("c1_r_rready", {31'b0, o_axi_rready}, 32'd1);
        chk("c1_r_wr_en", {31'b0, o_wr_en}, 32'd1);
        chk("c1_r_brep", {31'b0, o_block_replace}, 32'd1);
        chk("c1_r_offset", {31'b0, o_offset}, 32'd0);
        tick; #1;
        chk("c1_hit_rd_en", {31'b0, o_rd_en}, 32'd1);
        chk("c1_hit_stall", {31'b0, o_stall}, 32'd0);
        chk("c1_hit_wr_en", {31'b0, o_wr_en}, 32'd0);
        tick; i_addr = 32'h11C; #1;
        chk("c1_same_line_rd_en", {31'b0, o_rd_en}, 32'd1);

        // Cold straddling fetch at 0x1E: lines 0x000 then 0x020.
        tick; i_addr = 32'h1E; #1;
        chk("c2_n_stall", {31'b0, o_stall}, 32'd1);
        tick; #1;
        chk("c2_ara_addr", o_axi_araddr, 32'h000);
        chk("c2_ara_valid", {31'b0, o_axi_arvalid}, 32'd1);
        tick; #1;
        chk("c2_ra_wr_en", {31'b0, o_wr_en}, 32'd1);
        chk("c2_ra_offset", {31'b0, o_offset}, 32'd0);
        tick; #1;
        chk("c2_arb_addr", o_axi_araddr, 32'h020);
        chk("c2_arb_stall", {31'b0, o_stall}, 32'd1);
        tick; #1;
        chk("c2_rb_wr_en", {31'b0, o_wr_en}, 32'd1);
        chk("c2_rb_offset", {31'b0, o_offset}, 32'd1);
        tick; #1;
        chk("c2_hit_rd_en", {31'b0, o_rd_en}, 32'd1);
        chk("c2_hit_stall", {31'b0, o_stall}, 32'd0);

        // Fill line 0xFE0 (index 127), then fetch 0xFFE: only line B (0x1000) refills.
        tick; i_addr = 32'hFE0; #1;
        chk("c3_fe0_stall", {31'b0, o_stall}, 32'd1);
        tick; tick; tick; #1;
        chk("c3_fe0_rd_en", {31'b0, o_rd_en}, 32'd1);
        tick; i_addr = 32'hFFE; #1;
        chk("c3_ffe_stall", {31'b0, o_stall}, 32'd1);
        tick; #1;
        chk("c3_arb_addr", o_axi_araddr, 32'h1000);
        tick; #1;
        chk("c3_rb_wr_en", {31'b0, o_wr_en}, 32'd1);
        chk("c3_rb_offset", {31'b0, o_offset}, 32'd1);
        tick; #1;
        chk("c3_hit_rd_en", {31'b0, o_rd_en}, 32'd1);

        // Flush in IDLE still hits this cycle, then 0x100 misses; flush again in R_A.
        tick; i_addr = 32'h100; i_flush = 1'b1; #1;
        chk("c4_flush_idle_rd_en", {31'b0, o_rd_en}, 32'd1);
        tick; i_flush = 1'b0; #1;
        chk("c4_post_flush_stall", {31'b0, o_stall}, 32'd1);
        chk("c4_post_flush_rd_en", {31'b0, o_rd_en}, 32'd0);
        tick; #1;
        chk("c4_ar_addr", o_axi_araddr, 32'h100);
        tick; i_flush = 1'b1; #1;
        chk("c4_ra_wr_en", {31'b0, o_wr_en}, 32'd1);
        tick; i_flush = 1'b0; #1;
        chk("c4_remiss_stall", {31'b0, o_stall}, 32'd1);
        chk("c4_remiss_rd_en", {31'b0, o_rd_en}, 32'd0);
        tick; tick; tick; #1;
        chk("c4_refill_rd_en", {31'b0, o_rd_en}, 32'd1);

        // Error response on 0x200.
        tick; i_addr = 32'h200; i_axi_rresp = 2'b10; #1;
        chk("c5_n_stall", {31'b0, o_stall}, 32'd1);
        tick; #1;
        chk("c5_ar_addr", o_axi_araddr, 32'h200);
        tick; #1;
        chk("c5_err", {31'b0, o_fetch_err}, 32'd1);
        chk("c5_err_wr_en", {31'b0, o_wr_en}, 32'd0);
        chk("c5_err_brep", {31'b0, o_block_replace}, 32'd0);
        tick; i_axi_rresp = 2'b00; #1;
        chk("c5_err_cleared", {31'b0, o_fetch_err}, 32'd0);
        chk("c5_still_miss", {31'b0, o_stall}, 32'd1);
        chk("c5_idle_arvalid", {31'b0, o_axi_arvalid}, 32'd0);

        // Reset during AR_A: handshake drops, previously valid 0x100 misses.
        tick; #1;
        chk("c6_ar_valid", {31'b0, o_axi_arvalid}, 32'd1);
        i_rst = 1'b1; i_req = 1'b0; #1;
        chk("c6_rst_arvalid_now", {31'b0, o_axi_arvalid}, 32'd0);
        tick; i_rst = 1'b0; #1;
        chk("c6_post_rst_arvalid", {31'b0, o_axi_arvalid}, 32'd0);
        chk("c6_post_rst_rready", {31'b0, o_axi_rready}, 32'd0);
        chk("c6_post_rst_stall", {31'b0, o_stall}, 32'd0);
        tick; i_req = 1'b1; i_addr = 32'h100; #1;
        chk("c6_old_line_stall", {31'b0, o_stall}, 32'd1);
        chk("c6_old_line_rd_en", {31'b0, o_rd_en}, 32'd0);

        tick; i_req = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
